hr_clk: RTL and testbench
=========================

Name: hr_clk

Overview:
24-hour time-of-day counter producing hours, minutes and seconds as binary values. It sits behind a clock source and feeds display or timekeeping logic. By default each clock cycle is one second. An internal prescaler lets a faster clock be divided down to a one-second tick.

Parameters:
TICKS_PER_SEC, 1, number of clk cycles per one-second tick; must be ≥1; 1 means every rising clk edge is a tick.
PRESCALE_W, 32, width of the internal prescaler counter; must hold TICKS_PER_SEC-1.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
seconds  output  6  current seconds, binary, range 0..59.
minutes  output  6  current minutes, binary, range 0..59.
hours  output  5  current hours, binary, range 0..23.

Behaviour:
- Single clock domain (clk).
- reset is asynchronous and active-low.
  - While reset=0: seconds=0, minutes=0, hours=0 and prescaler=0, regardless of clk.
  - Assertion takes effect without waiting for a clk edge.
- All outputs come directly from registers; no combinational path from inputs to outputs.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 on each rising clk edge while reset=1.
  - The tick is asserted on the edge where prescaler == TICKS_PER_SEC-1; the prescaler then returns to 0.
  - With TICKS_PER_SEC=1 the prescaler is constant 0 and every edge is a tick.
- On a tick edge:
  - seconds<59: seconds+1.
  - seconds==59: seconds→0 and minutes advance.
- Minute advance:
  - minutes<59: minutes+1.
  - minutes==59: minutes→0 and hours advance.
- Hour advance:
  - hours<23: hours+1.
  - hours==23: hours→0.
- Full rollover: 23:59:59 → 00:00:00 on a single tick edge; all three fields update on the same edge (no ripple delay).
- Non-tick edges: all outputs hold.
- Latency: the first increment happens on the TICKS_PER_SEC-th rising edge after reset deasserts. Default: the first edge after deassert gives seconds=1.
- Reset mid-count: async clear to 00:00:00 with prescaler 0; counting restarts from zero after release.
- Reset released coincident with a clk edge: that edge is not required to count. The bench must release reset away from the active edge.
- Outputs never take out-of-range values (seconds/minutes >59, hours >23), including after reset and at every wrap.
- Synthesizable; no latches; no initial blocks required for function.

Test Plan:
- Reset: hold reset=0 with clk toggling for 3 cycles → seconds=0, minutes=0, hours=0; release → after 1 edge seconds=1, after 59 edges seconds=59.
- Minute carry: 60 edges after reset release → seconds=0, minutes=1, hours=0; 119 edges → 00:01:59; 120 edges → 00:02:00.
- Hour carry: 3599 edges → 00:59:59; 3600 edges → 01:00:00 (all fields update on the same edge).
- Day rollover: 86399 edges → 23:59:59; 86400 edges → 00:00:00; 86401 edges → 00:00:01.
- Async reset mid-operation: after 500 edges (00:08:20), drive reset=0 between clk edges → outputs read 0 before the next edge; release → counting resumes from 00:00:01 on the next tick.
- Prescaler: TICKS_PER_SEC=4 → seconds=0 for edges 1–3, seconds=1 at edge 4, seconds=15 at edge 60, 00:01:00 at edge 240.

Source files
------------

// File: rtl/hr_clk.sv
// 24-hour time-of-day counter (hours:minutes:seconds, binary) advanced by a
// one-second tick derived from clk through an internal prescaler.
module hr_clk #(
  parameter int TICKS_PER_SEC = 1,
  parameter int PRESCALE_W    = 32
) (
  input  logic       clk,
  input  logic       reset,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [4:0] hours
);

  localparam logic [PRESCALE_W-1:0] PRE_MAX = PRESCALE_W'(TICKS_PER_SEC - 1);

  logic [PRESCALE_W-1:0] prescale;
  logic                  tick;
  logic                  sec_wrap;
  logic                  min_wrap;
  logic                  hr_wrap;

  // With TICKS_PER_SEC=1, PRE_MAX is 0, so prescale never leaves 0 and every edge ticks.
  assign tick     = (prescale == PRE_MAX);
  assign sec_wrap = (seconds == 6'd59);
  assign min_wrap = (minutes == 6'd59);
  assign hr_wrap  = (hours == 5'd23);

  // Prescaler stage: divides clk down to the one-second tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescale <= '0;
    end else if (tick) begin
      prescale <= '0;
    end else begin
      prescale <= prescale + PRESCALE_W'(1);
    end
  end

  // Time-of-day stage: carries are decoded from current values so a full
  // 23:59:59 rollover lands on a single tick edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seconds <= '0;
      minutes <= '0;
      hours   <= '0;
    end else if (tick) begin
      seconds <= sec_wrap ? 6'd0 : seconds + 6'd1;
      if (sec_wrap) begin
        minutes <= min_wrap ? 6'd0 : minutes + 6'd1;
        if (min_wrap) begin
          hours <= hr_wrap ? 5'd0 : hours + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hr_clk.sv
// Bench for hr_clk: three instances on one clock (plain, reset-exercised,
// divide-by-4) compared every cycle against an elapsed-seconds model.
module tb_hr_clk;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, reset_b, reset_c;
  logic [5:0] sec_a, min_a, sec_b, min_b, sec_c, min_c;
  logic [4:0] hr_a, hr_b, hr_c;
  logic [16:0] a_hms, b_hms, c_hms;

  assign a_hms = {hr_a, min_a, sec_a};
  assign b_hms = {hr_b, min_b, sec_b};
  assign c_hms = {hr_c, min_c, sec_c};

  hr_clk #(.TICKS_PER_SEC(1), .PRESCALE_W(32)) u_a (
    .clk(clk), .reset(reset_a), .seconds(sec_a), .minutes(min_a), .hours(hr_a));
  hr_clk #(.TICKS_PER_SEC(1), .PRESCALE_W(32)) u_b (
    .clk(clk), .reset(reset_b), .seconds(sec_b), .minutes(min_b), .hours(hr_b));
  hr_clk #(.TICKS_PER_SEC(4), .PRESCALE_W(8)) u_c (
    .clk(clk), .reset(reset_c), .seconds(sec_c), .minutes(min_c), .hours(hr_c));

  // Count of rising edges seen with reset released, per instance.
  int unsigned n_a = 0, n_b = 0, n_c = 0;
  always @(posedge clk) begin
    n_a <= reset_a ? n_a + 1 : 0;
    n_b <= reset_b ? n_b + 1 : 0;
    n_c <= reset_c ? n_c + 1 : 0;
  end

  int total = 0;
  int bad   = 0;

  function automatic logic [16:0] ref_hms(input int unsigned secs);
    int unsigned t;
    t = secs % 86400;
    return {5'(t / 3600), 6'((t / 60) % 60), 6'(t % 60)};
  endfunction

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d:%0d:%0d want %0d:%0d:%0d", tag, $time,
               obs[16:12], obs[11:6], obs[5:0], exp[16:12], exp[11:6], exp[5:0]);
    end
  endtask

  initial begin
    int hold_b;
    int hold_c;
    hold_b  = 0;
    hold_c  = 0;
    reset_a = 1'b0;
    reset_b = 1'b0;
    reset_c = 1'b0;

    repeat (3) @(negedge clk);
    chk("a_reset", a_hms, 17'd0);
    chk("b_reset", b_hms, 17'd0);
    chk("c_reset", c_hms, 17'd0);

    // Release away from the active edge.
    reset_a = 1'b1;
    reset_b = 1'b1;
    reset_c = 1'b1;

    for (int k = 1; k <= 86401; k++) begin
      @(negedge clk);
      chk("a_run", a_hms, ref_hms(n_a));
      chk("b_run", b_hms, ref_hms(n_b));
      chk("c_run", c_hms, ref_hms(n_c / 4));

      case (k)
        1:     chk("a_e1",     a_hms, {5'd0,  6'd0,  6'd1});
        59:    chk("a_e59",    a_hms, {5'd0,  6'd0,  6'd59});
        60:    chk("a_e60",    a_hms, {5'd0,  6'd1,  6'd0});
        119:   chk("a_e119",   a_hms, {5'd0,  6'd1,  6'd59});
        120:   chk("a_e120",   a_hms, {5'd0,  6'd2,  6'd0});
        3599:  chk("a_e3599",  a_hms, {5'd0,  6'd59, 6'd59});
        3600:  chk("a_e3600",  a_hms, {5'd1,  6'd0,  6'd0});
        86399: chk("a_e86399", a_hms, {5'd23, 6'd59, 6'd59});
        86400: chk("a_e86400", a_hms, {5'd0,  6'd0,  6'd0});
        86401: chk("a_e86401", a_hms, {5'd0,  6'd0,  6'd1});
        default: ;
      endcase

      if (k <= 3) chk("c_pre_hold", c_hms, 17'd0);
      if (k == 4)   chk("c_e4",   c_hms, {5'd0, 6'd0, 6'd1});
      if (k == 60)  chk("c_e60",  c_hms, {5'd0, 6'd0, 6'd15});
      if (k == 240) chk("c_e240", c_hms, {5'd0, 6'd1, 6'd0});

      if (k == 500) begin
        chk("b_e500", b_hms, {5'd0, 6'd8, 6'd20});
        #1 reset_b = 1'b0;
        #1 chk("b_async_clr", b_hms, 17'd0);
      end
      if (k == 502) reset_b = 1'b1;
      if (k == 503) chk("b_resume", b_hms, {5'd0, 6'd0, 6'd1});

      if (k > 600) begin
        if (!reset_b) begin
          if (hold_b == 0) reset_b = 1'b1;
          else hold_b--;
        end else if ($urandom_range(0, 499) == 0) begin
          reset_b = 1'b0;
          hold_b  = int'($urandom_range(0, 2));
        end
      end
      if (k > 300) begin
        if (!reset_c) begin
          if (hold_c == 0) reset_c = 1'b1;
          else hold_c--;
        end else if ($urandom_range(0, 399) == 0) begin
          reset_c = 1'b0;
          hold_c  = int'($urandom_range(0, 2));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
